// File: rtl/decoder_2x4.sv
// Registered 2-to-4 one-hot decoder with optional saturating toggle counters.
// Define DECODER_2X4_TOGGLE_CNT_EN to compile in the input/output toggle counters.
module decoder_2x4 #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned IN_CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          in,
  input  logic                clr,
  output logic [3:0]          out,
  output logic [CNT_W-1:0]    out_toggles,
  output logic [IN_CNT_W-1:0] in_toggles,
  output logic                cnt_sat
);

  logic [3:0] out_d;

  always_comb begin
    out_d = 4'b0000;
    unique case (in)
      2'b00: out_d = 4'b0001;
      2'b01: out_d = 4'b0010;
      2'b10: out_d = 4'b0100;
      2'b11: out_d = 4'b1000;
      default: out_d = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= 4'b0000;
    end else begin
      out <= out_d;
    end
  end

`ifdef DECODER_2X4_TOGGLE_CNT_EN

  logic [1:0]          prev_in_q;
  logic [3:0]          out_diff;
  logic [1:0]          in_diff;
  logic [1:0]          out_inc;
  logic [1:0]          in_inc;
  logic [CNT_W:0]      out_sum;
  logic [IN_CNT_W:0]   in_sum;
  logic [CNT_W-1:0]    out_cnt_d;
  logic [IN_CNT_W-1:0] in_cnt_d;
  logic                sat_d;

  // Increments never exceed 2: out is one-hot or zero, in is 2 bits wide.
  always_comb begin
    out_diff = out ^ out_d;
    in_diff  = prev_in_q ^ in;
    out_inc  = 2'(out_diff[0]) + 2'(out_diff[1]) + 2'(out_diff[2]) + 2'(out_diff[3]);
    in_inc   = {in_diff[1] & in_diff[0], in_diff[1] ^ in_diff[0]};
    out_sum  = {1'b0, out_toggles} + (CNT_W + 1)'(out_inc);
    in_sum   = {1'b0, in_toggles} + (IN_CNT_W + 1)'(in_inc);
    out_cnt_d = out_sum[CNT_W] ? '1 : out_sum[CNT_W-1:0];
    in_cnt_d  = in_sum[IN_CNT_W] ? '1 : in_sum[IN_CNT_W-1:0];
    // Flag follows the counter by one cycle: it looks at the registered counts.
    sat_d = cnt_sat | (&out_toggles) | (&in_toggles);
    if (clr) begin
      out_cnt_d = '0;
      in_cnt_d  = '0;
      sat_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_in_q   <= 2'b00;
      out_toggles <= '0;
      in_toggles  <= '0;
      cnt_sat     <= 1'b0;
    end else begin
      prev_in_q   <= in;
      out_toggles <= out_cnt_d;
      in_toggles  <= in_cnt_d;
      cnt_sat     <= sat_d;
    end
  end

`else

  logic unused_clr;

  assign unused_clr  = clr;
  assign out_toggles = '0;
  assign in_toggles  = '0;
  assign cnt_sat     = 1'b0;

`endif

endmodule

// File: tb/tb_decoder_2x4.sv
// Directed self-checking bench for decoder_2x4; a second instance uses 4-bit counters
// to reach saturation quickly. Expected counts follow DECODER_2X4_TOGGLE_CNT_EN.
module tb_decoder_2x4;

`ifdef DECODER_2X4_TOGGLE_CNT_EN
  localparam bit En = 1'b1;
`else
  localparam bit En = 1'b0;
`endif

  logic        clk = 1'b0;
  bit          clk_run = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  in = 2'b11;
  logic        clr = 1'b0;
  logic [3:0]  out, out4;
  logic [15:0] out_toggles, in_toggles;
  logic [3:0]  out_toggles4, in_toggles4;
  logic        cnt_sat, cnt_sat4;

  int n_vec = 0;
  int n_err = 0;

  always #5 if (clk_run) clk = ~clk;

  decoder_2x4 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in          (in),
    .clr         (clr),
    .out         (out),
    .out_toggles (out_toggles),
    .in_toggles  (in_toggles),
    .cnt_sat     (cnt_sat)
  );

  decoder_2x4 #(.CNT_W(4), .IN_CNT_W(4)) dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in          (in),
    .clr         (clr),
    .out         (out4),
    .out_toggles (out_toggles4),
    .in_toggles  (in_toggles4),
    .cnt_sat     (cnt_sat4)
  );

  function automatic logic [15:0] e16(input int v);
    return En ? 16'(v) : 16'd0;
  endfunction

  function automatic logic [3:0] e4(input int v);
    return En ? 4'(v) : 4'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if (out !== 4'b0000 || out_toggles !== 16'd0 || in_toggles !== 16'd0 || cnt_sat !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: out=%b ot=%0d it=%0d sat=%b, want 0000 0 0 0",
               out, out_toggles, in_toggles, cnt_sat);
    end
    clk_run = 1'b1;
    tick();
    n_vec++;
    if (out !== 4'b0000 || out_toggles !== 16'd0) begin
      n_err++;
      $display("FAIL reset_held: out=%b ot=%0d, want 0000 0", out, out_toggles);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sequence();
    logic [1:0] ins [7] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b00, 2'b01};
    logic [3:0] exp [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0001, 4'b0010};
    for (int i = 0; i < 7; i++) begin
      in = ins[i];
      tick();
      n_vec++;
      if (out !== exp[i]) begin
        n_err++;
        $display("FAIL seq_out[%0d]: out=%b, want %b", i, out, exp[i]);
      end
    end
    n_vec++;
    if (out_toggles !== e16(13) || in_toggles !== e16(7)) begin
      n_err++;
      $display("FAIL seq_counts: ot=%0d it=%0d, want %0d %0d",
               out_toggles, in_toggles, e16(13), e16(7));
    end
  endtask

  task automatic test_hold();
    in = 2'b10;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++;
      if (out !== 4'b0100 || out_toggles !== e16(15) || in_toggles !== e16(9)) begin
        n_err++;
        $display("FAIL hold[%0d]: out=%b ot=%0d it=%0d, want 0100 %0d %0d",
                 i, out, out_toggles, in_toggles, e16(15), e16(9));
      end
    end
  endtask

  task automatic test_clr();
    in  = 2'b00;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_vec++;
    if (out !== 4'b0001 || out_toggles !== 16'd0 || in_toggles !== 16'd0 || cnt_sat !== 1'b0
        || out_toggles4 !== 4'd0 || cnt_sat4 !== 1'b0) begin
      n_err++;
      $display("FAIL clr_wins: out=%b ot=%0d it=%0d sat=%b ot4=%0d sat4=%b, want 0001 0 0 0 0 0",
               out, out_toggles, in_toggles, cnt_sat, out_toggles4, cnt_sat4);
    end
    tick();
    n_vec++;
    if (out !== 4'b0001 || out_toggles !== 16'd0 || in_toggles !== 16'd0) begin
      n_err++;
      $display("FAIL clr_idle: out=%b ot=%0d it=%0d, want 0001 0 0", out, out_toggles, in_toggles);
    end
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 12; i++) begin
      in = (i % 2 == 1) ? 2'b01 : 2'b00;
      tick();
      if (i == 7 || i == 8 || i == 9 || i == 12) begin
        n_vec++;
        if (out_toggles4 !== e4(i >= 8 ? 15 : 2 * i) || cnt_sat4 !== (En && i >= 9)) begin
          n_err++;
          $display("FAIL sat4[%0d]: ot4=%0d sat4=%b, want %0d %b", i, out_toggles4, cnt_sat4,
                   e4(i >= 8 ? 15 : 2 * i), En && i >= 9);
        end
      end
    end
    n_vec++;
    if (in_toggles4 !== e4(12) || out_toggles !== e16(24) || in_toggles !== e16(12)
        || cnt_sat !== 1'b0) begin
      n_err++;
      $display("FAIL sat_others: it4=%0d ot=%0d it=%0d sat=%b, want %0d %0d %0d 0",
               in_toggles4, out_toggles, in_toggles, cnt_sat, e4(12), e16(24), e16(12));
    end
  endtask

  task automatic test_async_reset_mid();
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (out !== 4'b0000 || out_toggles !== 16'd0 || in_toggles !== 16'd0 || cnt_sat4 !== 1'b0
        || out_toggles4 !== 4'd0) begin
      n_err++;
      $display("FAIL mid_reset: out=%b ot=%0d it=%0d ot4=%0d sat4=%b, want 0000 0 0 0 0",
               out, out_toggles, in_toggles, out_toggles4, cnt_sat4);
    end
    #1 rst_n = 1'b1;
    in = 2'b01;
    tick();
    n_vec++;
    if (out !== 4'b0010 || out_toggles !== e16(1) || in_toggles !== e16(1)) begin
      n_err++;
      $display("FAIL resume_1: out=%b ot=%0d it=%0d, want 0010 %0d %0d",
               out, out_toggles, in_toggles, e16(1), e16(1));
    end
    in = 2'b11;
    tick();
    n_vec++;
    if (out !== 4'b1000 || out_toggles !== e16(3) || in_toggles !== e16(2)) begin
      n_err++;
      $display("FAIL resume_2: out=%b ot=%0d it=%0d, want 1000 %0d %0d",
               out, out_toggles, in_toggles, e16(3), e16(2));
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_hold();
    test_clr();
    test_saturation();
    test_async_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
